// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - single-address I2C target with strobe-based byte interface
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [7:0] data_in,
    output logic       tx_req,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ACK_ADDR = 3'd2,
        S_RX       = 3'd3,
        S_TX       = 3'd4,
        S_ACK_RX   = 3'd5,
        S_ACK_TX   = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

    state_t     r_state, w_state;
    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic [7:0] r_shift, w_shift;
    logic [7:0] r_tx_shift, w_tx_shift;
    logic [2:0] r_cnt, w_cnt;
    logic       r_sda_out, w_sda_out;
    logic [7:0] r_data_out, w_data_out;
    logic       r_dv, w_dv;
    logic       r_tx_req, w_tx_req;
    logic       r_rw, w_rw;
    logic       r_phase, w_phase;

    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;
    assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
    assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;

    assign sda_out    = r_sda_out;
    assign data_out   = r_data_out;
    assign data_valid = r_dv;
    assign tx_req     = r_tx_req;
    assign state      = r_state;

    // Synchronizers reset to the idle-bus level so reset release sees no edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_d  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_d  <= 1'b1;
        end else begin
            r_scl_s1 <= sclk;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'h00;
            r_tx_shift <= 8'h00;
            r_cnt      <= 3'd0;
            r_sda_out  <= 1'b1;
            r_data_out <= 8'h00;
            r_dv       <= 1'b0;
            r_tx_req   <= 1'b0;
            r_rw       <= 1'b0;
            r_phase    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_tx_shift <= w_tx_shift;
            r_cnt      <= w_cnt;
            r_sda_out  <= w_sda_out;
            r_data_out <= w_data_out;
            r_dv       <= w_dv;
            r_tx_req   <= w_tx_req;
            r_rw       <= w_rw;
            r_phase    <= w_phase;
        end
    end

    // r_phase marks the second half of an ACK slot (line already driven / ACK seen).
    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_tx_shift = r_tx_shift;
        w_cnt      = r_cnt;
        w_sda_out  = r_sda_out;
        w_data_out = r_data_out;
        w_dv       = 1'b0;
        w_tx_req   = 1'b0;
        w_rw       = r_rw;
        w_phase    = r_phase;
        if (w_start) begin
            w_state   = S_ADDR;
            w_sda_out = 1'b1;
            w_cnt     = 3'd0;
            w_shift   = 8'h00;
            w_phase   = 1'b0;
        end else if (w_stop) begin
            w_state   = S_IDLE;
            w_sda_out = 1'b1;
            w_cnt     = 3'd0;
            w_phase   = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift = {r_shift[6:0], r_sda_s2};
                        w_cnt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_rw    = r_sda_s2;
                            w_phase = 1'b0;
                            w_state = (r_shift[6:0] == SLAVE_ADDR) ? S_ACK_ADDR : S_IGNORE;
                        end
                    end
                end
                S_ACK_ADDR: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_out = 1'b0;
                            w_phase   = 1'b1;
                        end else begin
                            w_phase = 1'b0;
                            if (r_rw) begin
                                w_tx_req   = 1'b1;
                                w_tx_shift = data_in;
                                w_sda_out  = data_in[7];
                                w_state    = S_TX;
                            end else begin
                                w_sda_out = 1'b1;
                                w_state   = S_RX;
                            end
                        end
                    end
                end
                S_RX: begin
                    if (w_scl_rise) begin
                        w_shift = {r_shift[6:0], r_sda_s2};
                        w_cnt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_data_out = {r_shift[6:0], r_sda_s2};
                            w_dv       = 1'b1;
                            w_phase    = 1'b0;
                            w_state    = S_ACK_RX;
                        end
                    end
                end
                S_ACK_RX: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_out = 1'b0;
                            w_phase   = 1'b1;
                        end else begin
                            w_sda_out = 1'b1;
                            w_phase   = 1'b0;
                            w_state   = S_RX;
                        end
                    end
                end
                S_TX: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 3'd7) begin
                            w_sda_out = 1'b1;
                            w_cnt     = 3'd0;
                            w_phase   = 1'b0;
                            w_state   = S_ACK_TX;
                        end else begin
                            w_tx_shift = {r_tx_shift[6:0], 1'b0};
                            w_sda_out  = r_tx_shift[6];
                            w_cnt      = r_cnt + 3'd1;
                        end
                    end
                end
                S_ACK_TX: begin
                    if (w_scl_rise) begin
                        if (r_sda_s2) begin
                            w_state = S_IGNORE;
                        end else begin
                            w_phase = 1'b1;
                        end
                    end else if (w_scl_fall && r_phase) begin
                        w_phase    = 1'b0;
                        w_tx_req   = 1'b1;
                        w_tx_shift = data_in;
                        w_sda_out  = data_in[7];
                        w_state    = S_TX;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - scoreboard bench for i2c_slave driven by a bit-level master model
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       sda_out;
    logic       tx_req;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] state;
    logic       w_bus;

    assign w_bus = m_sda & sda_out;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .sda_in(w_bus), .sda_out(sda_out),
        .data_in(data_in), .tx_req(tx_req), .data_out(data_out),
        .data_valid(data_valid), .state(state)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic       prev_dv = 1'b0;
    logic       prev_tx = 1'b0;
    logic       watch = 1'b0;
    int         low_cnt = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every strobe the DUT raises is matched against the queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (data_valid) begin
                if (exp_rx.size() == 0) chk("spurious data_valid", {31'd0, data_valid}, 32'd0);
                else chk("data_out", {24'd0, data_out}, {24'd0, exp_rx.pop_front()});
                chk("data_valid single", {31'd0, prev_dv | tx_req}, 32'd0);
            end
            if (tx_req) begin
                if (exp_tx.size() == 0) chk("spurious tx_req", {31'd0, tx_req}, 32'd0);
                else chk("tx_req data_in", {24'd0, data_in}, {24'd0, exp_tx.pop_front()});
                chk("tx_req single", {31'd0, prev_tx}, 32'd0);
            end
        end
        prev_dv <= data_valid;
        prev_tx <= tx_req;
        if (watch && !sda_out) low_cnt <= low_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bitx(input logic b, output logic o);
        wait_clk(4); m_sda = b;
        wait_clk(4); sclk = 1'b1;
        wait_clk(4); o = w_bus;
        wait_clk(4); sclk = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clk(4); m_sda = 1'b1;
        wait_clk(4); sclk = 1'b1;
        wait_clk(4); m_sda = 1'b0;
        wait_clk(4); sclk = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(4); m_sda = 1'b0;
        wait_clk(4); sclk = 1'b1;
        wait_clk(4); m_sda = 1'b1;
        wait_clk(8);
    endtask

    task automatic send8(input logic [7:0] b);
        logic o;
        for (int i = 7; i >= 0; i--) bitx(b[i], o);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send8(b);
        bitx(1'b1, ack);
    endtask

    task automatic rd8(output logic [7:0] b);
        logic o;
        for (int i = 7; i >= 0; i--) begin
            bitx(1'b1, o);
            b[i] = o;
        end
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        logic       found;

        wait_clk(3);
        chk("reset sda_out", {31'd0, sda_out}, 32'd1);
        chk("reset data_out", {24'd0, data_out}, 32'd0);
        chk("reset data_valid", {31'd0, data_valid}, 32'd0);
        chk("reset tx_req", {31'd0, tx_req}, 32'd0);
        chk("reset state", {29'd0, state}, 32'd0);
        rst = 1'b1;
        wait_clk(4);

        // Write 0xA5 to 0x50
        exp_rx.push_back(8'hA5);
        i2c_start();
        chk("write start state", {29'd0, state}, 32'd1);
        send_byte(8'hA0, ack);
        chk("write addr ack", {31'd0, ack}, 32'd0);
        send_byte(8'hA5, ack);
        chk("write data ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        chk("write end state", {29'd0, state}, 32'd0);
        chk("write data_out", {24'd0, data_out}, 32'hA5);

        // Address mismatch
        watch = 1'b1;
        i2c_start();
        send_byte(8'hA2, ack);
        chk("mismatch addr nack", {31'd0, ack}, 32'd1);
        chk("mismatch state", {29'd0, state}, 32'd7);
        send_byte(8'h3C, ack);
        chk("mismatch data nack", {31'd0, ack}, 32'd1);
        chk("mismatch state after data", {29'd0, state}, 32'd7);
        i2c_stop();
        watch = 1'b0;
        chk("mismatch end state", {29'd0, state}, 32'd0);
        chk("mismatch sda_out low cycles", low_cnt, 32'd0);

        // Single-byte read, master NACKs
        data_in = 8'hF6;
        exp_tx.push_back(8'hF6);
        i2c_start();
        send_byte(8'hA1, ack);
        chk("read addr ack", {31'd0, ack}, 32'd0);
        rd8(rb);
        chk("read byte", {24'd0, rb}, 32'hF6);
        bitx(1'b1, ack);
        chk("read 9th bit released", {31'd0, ack}, 32'd1);
        chk("read nack state", {29'd0, state}, 32'd7);
        i2c_stop();
        chk("read end state", {29'd0, state}, 32'd0);

        // Two-byte read, master ACKs the first
        data_in = 8'hF6;
        exp_tx.push_back(8'hF6);
        exp_tx.push_back(8'h81);
        i2c_start();
        send_byte(8'hA1, ack);
        chk("read2 addr ack", {31'd0, ack}, 32'd0);
        rd8(rb);
        chk("read2 byte0", {24'd0, rb}, 32'hF6);
        data_in = 8'h81;
        bitx(1'b0, ack);
        rd8(rb);
        chk("read2 byte1", {24'd0, rb}, 32'h81);
        bitx(1'b1, ack);
        chk("read2 9th bit released", {31'd0, ack}, 32'd1);
        i2c_stop();
        chk("read2 end state", {29'd0, state}, 32'd0);

        // Repeated START after 4 write bits, then a read
        i2c_start();
        send_byte(8'hA0, ack);
        chk("rs write addr ack", {31'd0, ack}, 32'd0);
        bitx(1'b1, ack); bitx(1'b0, ack); bitx(1'b1, ack); bitx(1'b1, ack);
        i2c_start();
        chk("rs state", {29'd0, state}, 32'd1);
        data_in = 8'hC3;
        exp_tx.push_back(8'hC3);
        send_byte(8'hA1, ack);
        chk("rs read addr ack", {31'd0, ack}, 32'd0);
        rd8(rb);
        chk("rs read byte", {24'd0, rb}, 32'hC3);
        bitx(1'b1, ack);
        i2c_stop();
        chk("rs end state", {29'd0, state}, 32'd0);
        chk("rs data_out kept", {24'd0, data_out}, 32'hA5);

        // Reset while the data acknowledge is being driven
        exp_rx.push_back(8'h5A);
        i2c_start();
        send_byte(8'hA0, ack);
        chk("rst addr ack", {31'd0, ack}, 32'd0);
        send8(8'h5A);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (state == 3'd5 && sda_out == 1'b0) found = 1'b1;
        end
        chk("rst reached ACK_RX drive", {31'd0, found}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async rst sda_out", {31'd0, sda_out}, 32'd1);
        chk("async rst state", {29'd0, state}, 32'd0);
        chk("async rst data_out", {24'd0, data_out}, 32'd0);
        chk("async rst data_valid", {31'd0, data_valid}, 32'd0);
        chk("async rst tx_req", {31'd0, tx_req}, 32'd0);
        sclk = 1'b1;
        m_sda = 1'b1;
        wait_clk(4);
        rst = 1'b1;
        wait_clk(8);
        chk("post reset state", {29'd0, state}, 32'd0);
        chk("post reset sda_out", {31'd0, sda_out}, 32'd1);

        chk("rx queue drained", exp_rx.size(), 32'd0);
        chk("tx queue drained", exp_tx.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Responder end of the team's I2C link: a single-address I2C target that sits on the same `sclk`/`sda` wires driven by `master` and answers its transactions. Oversamples the bus with the system clock, detects START/STOP, matches a 7-bit address, and then either receives write bytes or serves read bytes. Bytes move to and from local logic through simple one-cycle strobes.

## Interface
- `SLAVE_ADDR`, default 7'h50, 7-bit bus address the block answers to.
- `clk  input  1  system clock; all logic on posedge.`
- `rst  input  1  asynchronous, active-low reset.`
- `sclk  input  1  bus clock from the master; asynchronous to clk.`
- `sda_in  input  1  bus data as seen on the wire; asynchronous to clk.`
- `sda_out  output  1  slave drive: 0 pulls SDA low, 1 releases.`
- `data_in  input  8  byte to return on a master read; sampled when tx_req pulses.`
- `tx_req  output  1  one-cycle pulse when data_in is captured for transmission.`
- `data_out  output  8  last byte received from a master write.`
- `data_valid  output  1  one-cycle pulse when data_out updates.`
- `state  output  3  current FSM state, for debug and bench.`

## Operation
- `sclk` and `sda_in` pass through 2-flop synchronizers. Rise and fall edges are detected on the synchronized copies.
- START: synchronized SDA falls while synchronized SCLK is high. STOP: SDA rises while SCLK is high. Both are recognized in every state.
- Bits are sampled on SCLK rise, MSB first. `sda_out` changes only on SCLK fall, except when START, STOP or reset release the line.
- States:
  - IDLE=0: waits for START.
  - ADDRESSING=1: shifts 8 bits (7 address bits plus R/W).
  - ACK_ADDR=2: drives the address acknowledge.
  - RX_DATA=3: receives a write byte.
  - TX_DATA=4: sends a read byte.
  - ACK_RX=5: drives the data acknowledge after a received byte.
  - ACK_TX=6: samples the master's acknowledge after a sent byte.
  - IGNORE=7: not addressed; waits for START or STOP.
- ADDRESSING: after the 8th rise, if `shift[7:1]==SLAVE_ADDR` go to ACK_ADDR, else go to IGNORE. In ACK_ADDR, `sda_out`=0 from the next fall until the following fall.
- At the fall that ends ACK_ADDR:
  - R/W=0: release the line and go to RX_DATA.
  - R/W=1: pulse `tx_req`, load `data_in`, drive its MSB on that same fall, go to TX_DATA.
- RX_DATA: on the 8th rise, `data_out` is loaded and `data_valid` pulses in the same clk cycle. Then ACK_RX drives 0 for one SCLK low/high period and returns to RX_DATA. Receive never NACKs.
- TX_DATA: shifts on each fall. After the 8th bit, release at the fall and go to ACK_TX. Sample SDA at the next rise:
  - 0 (ACK): at the next fall, pulse `tx_req`, reload, drive the MSB, go to TX_DATA.
  - 1 (NACK): go to IGNORE with the line released.
- START in any state, including mid-byte (repeated start): release `sda_out`, clear the bit counter, go to ADDRESSING.
- STOP in any state: release the line and go to IDLE.
- Bit counter is 3 bits and wraps from 7 to 0 at each byte boundary.

## Timing
- Reset values: `sda_out`=1, `data_out`=8'h00, `data_valid`=0, `tx_req`=0, `state`=IDLE. Shift register and counter are 0.
- Reset is asynchronous. Asserting it mid-transfer releases `sda_out` immediately, with no clk edge required.
- Edge-detect latency: an edge on a raw input is acted on at the 3rd clk posedge after it.
  - `sda_out` therefore updates 3 clk after a raw SCLK fall.
  - Requirement on the master: SCLK low time ≥ 6 clk, high time ≥ 4 clk.
  - Requirement on the master: SDA stable ≥ 3 clk around each SCLK rise.
- If an SCLK edge and a START/STOP are detected in the same cycle, START/STOP wins.
- `data_valid` and `tx_req` are never high for more than one clk and never high in the same cycle.

## Test plan
- Write transaction: START, address 0x50 with W, byte 0xA5, STOP → `sda_out`=0 during both ACK slots; `data_out`=8'hA5; `data_valid` high exactly one clk; `state` ends at 0.
- Address mismatch: address 0x51 with W, data 0x3C → `sda_out` stays 1 for the whole transaction; no `data_valid`; `state`=7 until STOP, then 0.
- Read transaction: address 0x50 with R, `data_in`=8'hF6, master NACKs → `sda_out` bits 1,1,1,1,0,1,1,0; one `tx_req`; line released at the 9th bit; IGNORE until STOP.
- Two-byte read: master ACKs the first byte → second `tx_req` pulse; new `data_in` value 8'h81 appears on `sda_out` MSB first.
- Repeated START after 4 data bits of a write, then a read of 0x50 → partial byte discarded, no `data_valid`, address ACK driven, read proceeds.
- `rst` driven low while the slave is in ACK_RX driving `sda_out`=0 → `sda_out`=1 before the next clk edge; all outputs return to reset values.
